// File: rtl/timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package timer_pkg;

   localparam int CTL_ITO   = 0;
   localparam int CTL_CONT  = 1;
   localparam int CTL_START = 2;
   localparam int CTL_STOP  = 3;
   localparam int CTL_PSE   = 4;

   localparam int ST_TO  = 0;
   localparam int ST_RUN = 1;

   localparam logic [3:0] OFF_STATUS      = 4'd0;
   localparam logic [3:0] OFF_CONTROL     = 4'd1;
   localparam logic [3:0] OFF_PERIOD_BASE = 4'd2;

   localparam logic [3:0] OFF_PEND     = 4'd0;
   localparam logic [3:0] OFF_PRESCALE = 4'd1;
   localparam logic [3:0] OFF_GSTART   = 4'd2;
   localparam logic [3:0] OFF_GSTOP    = 4'd3;

   // Snapshot halfwords sit directly after the period halfwords.
   function automatic logic [3:0] snap_base(input int hw);
      return 4'(2 + hw);
   endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting interval timer: counter, period, snapshot, RUN/TO and its register read mux.
module timer_channel
   import timer_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int CNT_W        = 64,
   parameter int RESET_PERIOD = 499
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [3:0]        off,
   input  logic [DATA_W-1:0] wdata,
   input  logic              tick,
   input  logic              gstart,
   input  logic              gstop,
   input  logic              pend_clr,
   output logic [DATA_W-1:0] rdata,
   output logic              timeout,
   output logic              irq
);

   localparam int         HW        = CNT_W / DATA_W;
   localparam logic [3:0] SNAP_BASE = snap_base(HW);

   logic [CNT_W-1:0] cnt, period, snap;
   logic [4:0]       ctrl;
   logic             run, zero_q, force_reload;
   logic             zero, per_wr, snap_wr, start, stop, to_clr, step;

   assign zero   = (cnt == '0);
   assign start  = (wr_en && off == OFF_CONTROL && wdata[CTL_START]) || gstart;
   assign stop   = (wr_en && off == OFF_CONTROL && wdata[CTL_STOP]) || gstop;
   assign to_clr = (wr_en && off == OFF_STATUS) || pend_clr;
   // A one-shot channel parks at zero instead of reloading.
   assign step   = run && !(zero && !ctrl[CTL_CONT]) && (ctrl[CTL_PSE] ? tick : 1'b1);
   assign irq    = timeout & ctrl[CTL_ITO];

   always_comb begin
      per_wr  = 1'b0;
      snap_wr = 1'b0;
      for (int h = 0; h < HW; h++) begin
         if (off == 4'(OFF_PERIOD_BASE + h)) per_wr  = wr_en;
         if (off == 4'(SNAP_BASE + h))       snap_wr = wr_en;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt          <= CNT_W'(RESET_PERIOD);
         period       <= CNT_W'(RESET_PERIOD);
         snap         <= '0;
         ctrl         <= '0;
         run          <= 1'b0;
         timeout      <= 1'b0;
         zero_q       <= (RESET_PERIOD == 0);
         force_reload <= 1'b0;
      end else begin
         force_reload <= per_wr;
         zero_q       <= zero;
         for (int h = 0; h < HW; h++)
            if (wr_en && off == 4'(OFF_PERIOD_BASE + h)) period[h*DATA_W +: DATA_W] <= wdata;
         if (wr_en && off == OFF_CONTROL) ctrl <= wdata[4:0];
         if (snap_wr) snap <= cnt;

         if (force_reload)  cnt <= period;
         else if (step)     cnt <= zero ? period : cnt - 1'b1;

         if (start)                                                  run <= 1'b1;
         else if (stop || force_reload || (zero && !ctrl[CTL_CONT])) run <= 1'b0;

         if (to_clr)               timeout <= 1'b0;
         else if (zero && !zero_q) timeout <= 1'b1;
      end
   end

   always_comb begin
      rdata = '0;
      if (off == OFF_STATUS) begin
         rdata[ST_TO]  = timeout;
         rdata[ST_RUN] = run;
      end
      if (off == OFF_CONTROL) rdata[4:0] = ctrl;
      for (int h = 0; h < HW; h++) begin
         if (off == 4'(OFF_PERIOD_BASE + h)) rdata = period[h*DATA_W +: DATA_W];
         if (off == 4'(SNAP_BASE + h))       rdata = snap[h*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/avalon_multi_timer.sv
// Avalon-MM multi-channel interval timer: address decode, shared prescaler, global
// pending/start/stop registers and the registered read path.
module avalon_multi_timer
   import timer_pkg::*;
#(
   parameter int  DATA_W       = 16,
   parameter int  CNT_W        = 64,
   parameter int  NUM_CH       = 4,
   parameter int  RESET_PERIOD = 499,
   localparam int CH_BITS      = $clog2(NUM_CH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CH_BITS+3:0]   address,
   input  logic                 chipselect,
   input  logic                 write_n,
   input  logic [DATA_W-1:0]    writedata,
   output logic [DATA_W-1:0]    readdata,
   output logic                 irq,
   output logic [NUM_CH-1:0]    irq_vec
);

   logic [CH_BITS-1:0]             ch_sel;
   logic [3:0]                     off;
   logic                           wr, gwr, tick;
   logic [DATA_W-1:0]              pscale, pcnt, rd_mux;
   logic [NUM_CH-1:0]              ch_wr, gstart, gstop, pend_clr, to_vec;
   logic [NUM_CH-1:0][DATA_W-1:0]  ch_rdata;

   assign ch_sel   = address[CH_BITS+3:4];
   assign off      = address[3:0];
   assign wr       = chipselect & ~write_n;
   assign gwr      = wr && (ch_sel == CH_BITS'(NUM_CH));
   assign tick     = (pcnt == pscale);
   assign gstart   = (gwr && off == OFF_GSTART) ? writedata[NUM_CH-1:0] : '0;
   assign gstop    = (gwr && off == OFF_GSTOP)  ? writedata[NUM_CH-1:0] : '0;
   assign pend_clr = (gwr && off == OFF_PEND)   ? writedata[NUM_CH-1:0] : '0;
   assign irq      = |irq_vec;

   always_comb begin
      ch_wr = '0;
      for (int i = 0; i < NUM_CH; i++)
         ch_wr[i] = wr && (ch_sel == CH_BITS'(i));
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      timer_channel #(
         .DATA_W       (DATA_W),
         .CNT_W        (CNT_W),
         .RESET_PERIOD (RESET_PERIOD)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (ch_wr[i]),
         .off      (off),
         .wdata    (writedata),
         .tick     (tick),
         .gstart   (gstart[i]),
         .gstop    (gstop[i]),
         .pend_clr (pend_clr[i]),
         .rdata    (ch_rdata[i]),
         .timeout  (to_vec[i]),
         .irq      (irq_vec[i])
      );
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (ch_sel == CH_BITS'(i)) rd_mux = ch_rdata[i];
      if (ch_sel == CH_BITS'(NUM_CH)) begin
         case (off)
            OFF_PEND:     rd_mux[NUM_CH-1:0] = to_vec;
            OFF_PRESCALE: rd_mux = pscale;
            default:      rd_mux = '0;
         endcase
      end
   end

   // Prescaler counts 0..P; rewriting P restarts the tick phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt     <= '0;
         pscale   <= '0;
         readdata <= '0;
      end else begin
         if (gwr && off == OFF_PRESCALE) begin
            pscale <= writedata;
            pcnt   <= '0;
         end else if (tick) begin
            pcnt <= '0;
         end else begin
            pcnt <= pcnt + 1'b1;
         end
         readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Directed bench for avalon_multi_timer (4 channels, 64-bit counters on a 16-bit bus).
module tb_avalon_multi_timer;

   localparam int CH_BITS = 3;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [CH_BITS+3:0]   address = '0;
   logic                 chipselect = 1'b0;
   logic                 write_n = 1'b1;
   logic [15:0]          writedata = '0;
   logic [15:0]          readdata;
   logic                 irq;
   logic [3:0]           irq_vec;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] d;
   int          k;

   avalon_multi_timer #(
      .DATA_W       (16),
      .CNT_W        (64),
      .NUM_CH       (4),
      .RESET_PERIOD (499)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .irq_vec    (irq_vec)
   );

   always #5 clk = ~clk;

   task automatic wr(input int ch, input int off, input logic [15:0] val);
      @(negedge clk);
      address    = {3'(ch), 4'(off)};
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = val;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input int ch, input int off, output logic [15:0] val);
      @(negedge clk);
      address = {3'(ch), 4'(off)};
      @(negedge clk);
      val = readdata;
   endtask

   task automatic wait_irq(input int ch, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!irq_vec[ch] && cyc < 60);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++; if (readdata !== 16'h0) begin errors++; $display("FAIL reset_readdata got %h exp 0000", readdata); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      checks++; if (irq_vec !== 4'b0) begin errors++; $display("FAIL reset_irq_vec got %b exp 0000", irq_vec); end
      reset = 1'b0;
      rd(0, 2, d);
      checks++; if (d !== 16'h01F3) begin errors++; $display("FAIL reset_period got %h exp 01f3", d); end
      rd(3, 3, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_period_hw1 got %h exp 0000", d); end
      rd(0, 0, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_status got %h exp 0000", d); end
      rd(4, 1, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_prescale got %h exp 0000", d); end
   endtask

   task automatic test_periodic;
      do_reset;
      wr(0, 2, 16'd4); wr(0, 3, 16'd0); wr(0, 4, 16'd0); wr(0, 5, 16'd0);
      wr(0, 1, 16'h0007);
      wait_irq(0, k);
      checks++; if (k !== 5) begin errors++; $display("FAIL periodic_first_to got %0d cycles exp 5", k); end
      wr(0, 0, 16'h0);
      checks++; if (irq_vec[0] !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL periodic_clear got irq_vec=%b irq=%b exp 0", irq_vec, irq); end
      wait_irq(0, k);
      checks++; if (k !== 3) begin errors++; $display("FAIL periodic_second_to got %0d cycles exp 3", k); end
      repeat (3) @(negedge clk);
      wr(0, 0, 16'h0);
      checks++; if (irq_vec[0] !== 1'b0) begin errors++; $display("FAIL periodic_clear_wins got %b exp 0", irq_vec[0]); end
      wait_irq(0, k);
      checks++; if (k !== 5) begin errors++; $display("FAIL periodic_after_clear got %0d cycles exp 5", k); end
   endtask

   task automatic test_oneshot;
      do_reset;
      wr(1, 2, 16'd3);
      wr(1, 1, 16'h0004);
      rd(1, 0, d);
      checks++; if (d !== 16'h0002) begin errors++; $display("FAIL oneshot_running got %h exp 0002", d); end
      repeat (5) @(negedge clk);
      rd(1, 0, d);
      checks++; if (d !== 16'h0001) begin errors++; $display("FAIL oneshot_done got %h exp 0001", d); end
      wr(1, 6, 16'h0);
      rd(1, 6, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL oneshot_hold_zero got %h exp 0000", d); end
      checks++; if (irq_vec !== 4'b0) begin errors++; $display("FAIL oneshot_no_ito got %b exp 0000", irq_vec); end
   endtask

   task automatic test_prescale;
      do_reset;
      wr(4, 1, 16'd2);
      wr(2, 2, 16'd2);
      wr(2, 1, 16'd21);
      wait_irq(2, k);
      checks++; if (k !== 6) begin errors++; $display("FAIL prescale_to got %0d cycles exp 6", k); end
      wr(2, 0, 16'h0);
      wr(2, 2, 16'd2);
      wr(4, 1, 16'd2);
      wr(2, 1, 16'd21);
      wr(4, 1, 16'd2);
      wait_irq(2, k);
      checks++; if (k !== 4) begin errors++; $display("FAIL prescale_rephase got %0d cycles exp 4", k); end
   endtask

   task automatic test_gstart;
      do_reset;
      wr(0, 2, 16'd3); wr(1, 2, 16'd3); wr(3, 2, 16'd3);
      wr(0, 1, 16'h1); wr(1, 1, 16'h1); wr(3, 1, 16'h1);
      wr(4, 2, 16'h000B);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (irq_vec === 4'b0 && k < 60);
      checks++; if (k !== 4) begin errors++; $display("FAIL gstart_to_time got %0d cycles exp 4", k); end
      checks++; if (irq_vec !== 4'b1011) begin errors++; $display("FAIL gstart_to_set got %b exp 1011", irq_vec); end
      rd(4, 0, d);
      checks++; if (d !== 16'h000B) begin errors++; $display("FAIL gstart_pend got %h exp 000b", d); end
      wr(4, 0, 16'h0001);
      rd(4, 0, d);
      checks++; if (d !== 16'h000A) begin errors++; $display("FAIL pend_w1c got %h exp 000a", d); end
      checks++; if (irq_vec !== 4'b1010) begin errors++; $display("FAIL pend_w1c_irq got %b exp 1010", irq_vec); end
   endtask

   task automatic test_period_write;
      do_reset;
      wr(0, 1, 16'h0006);
      repeat (3) @(negedge clk);
      wr(0, 2, 16'd100);
      rd(0, 0, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL period_wr_stops got %h exp 0000", d); end
      wr(0, 6, 16'h0);
      rd(0, 6, d);
      checks++; if (d !== 16'd100) begin errors++; $display("FAIL period_wr_reload got %h exp 0064", d); end
      wr(0, 1, 16'h000E);
      rd(0, 0, d);
      checks++; if (d !== 16'h0002) begin errors++; $display("FAIL start_beats_stop got %h exp 0002", d); end
      rd(0, 1, d);
      checks++; if (d !== 16'h000E) begin errors++; $display("FAIL control_readback got %h exp 000e", d); end
   endtask

   task automatic test_snap;
      logic [15:0] exp_a [4];
      logic [15:0] exp_b [4];
      exp_a = '{16'h0002, 16'h0000, 16'h0001, 16'h0000};
      exp_b = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
      do_reset;
      wr(0, 2, 16'd2); wr(0, 3, 16'd0); wr(0, 4, 16'd1); wr(0, 5, 16'd0);
      wr(0, 7, 16'h0);
      for (int h = 0; h < 4; h++) begin
         rd(0, 6 + h, d);
         checks++; if (d !== exp_a[h]) begin errors++; $display("FAIL snap_hw%0d got %h exp %h", h, d, exp_a[h]); end
      end
      wr(0, 1, 16'h0004);
      @(negedge clk);
      wr(4, 3, 16'h0001);
      wr(0, 8, 16'h0);
      for (int h = 0; h < 4; h++) begin
         rd(0, 6 + h, d);
         checks++; if (d !== exp_b[h]) begin errors++; $display("FAIL snap_borrow_hw%0d got %h exp %h", h, d, exp_b[h]); end
      end
      rd(0, 12, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL unmapped_read got %h exp 0000", d); end
   endtask

   task automatic test_reset_mid;
      do_reset;
      wr(0, 2, 16'd1);
      wr(0, 1, 16'h0007);
      wait_irq(0, k);
      checks++; if (k !== 2) begin errors++; $display("FAIL mid_to got %0d cycles exp 2", k); end
      address = {3'd4, 4'd0};
      repeat (2) @(negedge clk);
      checks++; if (readdata !== 16'h0001) begin errors++; $display("FAIL mid_pend got %h exp 0001", readdata); end
      #2 reset = 1'b1;
      #1;
      checks++; if (readdata !== 16'h0000 || irq !== 1'b0 || irq_vec !== 4'b0) begin
         errors++; $display("FAIL mid_async_reset got rd=%h irq=%b vec=%b exp 0", readdata, irq, irq_vec);
      end
      @(negedge clk);
      reset = 1'b0;
      wr(0, 6, 16'h0);
      rd(0, 6, d);
      checks++; if (d !== 16'h01F3) begin errors++; $display("FAIL mid_counter got %h exp 01f3", d); end
      rd(0, 0, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mid_status got %h exp 0000", d); end
   endtask

   initial begin
      test_reset;
      test_periodic;
      test_oneshot;
      test_prescale;
      test_gstart;
      test_period_write;
      test_snap;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
